cart_mem_arbiter: RTL and testbench

//  Shares the cartridge's external async SRAM/flash between two requesters: Game Boy bus accesses

---
 rtl/cart_mem_pkg.sv | 35 +++
 rtl/cart_mem_timer.sv | 27 ++
 rtl/cart_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 539 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mem_pkg.sv
// Shared types and default timing for the cartridge memory arbiter.
// Timing values are cycle counts; dwell() turns them into timer loads.
package cart_mem_pkg;

    localparam int CNT_W          = 8;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_ACCESS_CYC = 3;
    localparam int DEF_WE_CYC     = 2;
    localparam int DEF_TURN_CYC   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_READ,
        ST_WRITE,
        ST_TURN
    } state_t;

    typedef enum logic {
        GNT_GB,
        GNT_HOST
    } gnt_t;

    typedef struct packed {
        logic        we;
        logic        ram;
        logic [20:0] adr;
        logic [7:0]  wdata;
    } req_t;

    function automatic logic [CNT_W-1:0] dwell(int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/cart_mem_timer.sv
// Loadable down-counter with a zero flag.
// Sequences the dwell time of each arbiter state.
module cart_mem_timer
    import cart_mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge SRAM/flash between the GB bus and a host loader.
// GB has strict priority; the host is served only when no GB access is due.
module cart_mem_arbiter
    import cart_mem_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int ACCESS_CYC = DEF_ACCESS_CYC,
    parameter int WE_CYC     = DEF_WE_CYC,
    parameter int TURN_CYC   = DEF_TURN_CYC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        gb_stb,
    input  logic        gb_sel_rom,
    input  logic        gb_sel_ram,
    input  logic        gb_we,
    input  logic [20:0] gb_adr,
    input  logic [7:0]  gb_wdata,
    output logic [7:0]  gb_rdata,
    output logic        gb_done,
    output logic        gb_overrun,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [21:0] host_adr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        host_ack,
    output logic [20:0] mem_adr,
    output logic [7:0]  mem_dq_o,
    input  logic [7:0]  mem_dq_i,
    output logic        mem_dq_oe,
    output logic        mem_ce_rom_n,
    output logic        mem_ce_ram_n,
    output logic        mem_oe_n,
    output logic        mem_we_n
);

    state_t           state;
    gnt_t             gnt;
    logic             cur_we;
    req_t             slot;
    logic             slot_vld;
    req_t             gb_new;
    req_t             host_new;
    req_t             gnt_req;
    logic             gb_ok;
    logic             gb_due;
    logic             grant_gb;
    logic             grant_host;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    // GB writes may only target RAM; ROM is programmed from the host.
    assign gb_ok = gb_stb &&
                   ((gb_sel_ram && !gb_sel_rom) ||
                    (gb_sel_rom && !gb_we));

    assign gb_new = '{we: gb_we, ram: ~gb_sel_rom,
                      adr: gb_adr, wdata: gb_wdata};

    assign host_new = '{we: host_we, ram: host_adr[21],
                        adr: host_adr[20:0], wdata: host_wdata};

    assign gb_due     = gb_ok || slot_vld;
    assign grant_gb   = (state == ST_IDLE) && gb_due;
    assign grant_host = (state == ST_IDLE) && !gb_due && host_req;
    assign gnt_req    = grant_gb ? (gb_ok ? gb_new : slot) : host_new;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (grant_gb || grant_host) begin
                    tmr_load = 1'b1;
                    tmr_val  = dwell(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = cur_we ? dwell(WE_CYC) : dwell(ACCESS_CYC);
                end
            end
            ST_READ, ST_WRITE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = dwell(TURN_CYC);
                end
            end
            default: ;
        endcase
    end

    cart_mem_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot       <= '0;
            slot_vld   <= 1'b0;
            gb_overrun <= 1'b0;
        end else begin
            if (gb_ok) begin
                slot <= gb_new;
                if (slot_vld) gb_overrun <= 1'b1;
            end
            if (grant_gb) begin
                slot_vld <= 1'b0;
            end else if (gb_ok) begin
                slot_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            gnt          <= GNT_GB;
            cur_we       <= 1'b0;
            mem_adr      <= '0;
            mem_dq_o     <= '0;
            mem_dq_oe    <= 1'b0;
            mem_ce_rom_n <= 1'b1;
            mem_ce_ram_n <= 1'b1;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            gb_rdata     <= '0;
            host_rdata   <= '0;
            gb_done      <= 1'b0;
            host_ack     <= 1'b0;
        end else begin
            gb_done  <= 1'b0;
            host_ack <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (grant_gb || grant_host) begin
                        gnt          <= grant_gb ? GNT_GB : GNT_HOST;
                        cur_we       <= gnt_req.we;
                        mem_adr      <= gnt_req.adr;
                        mem_dq_o     <= gnt_req.wdata;
                        mem_dq_oe    <= gnt_req.we;
                        mem_ce_rom_n <= gnt_req.ram;
                        mem_ce_ram_n <= ~gnt_req.ram;
                        state        <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) begin
                        if (cur_we) begin
                            mem_we_n <= 1'b0;
                            state    <= ST_WRITE;
                        end else begin
                            mem_oe_n <= 1'b0;
                            state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (tmr_zero) begin
                        mem_oe_n <= 1'b1;
                        if (gnt == GNT_GB) begin
                            gb_rdata <= mem_dq_i;
                            gb_done  <= 1'b1;
                        end else begin
                            host_rdata <= mem_dq_i;
                            host_ack   <= 1'b1;
                        end
                        state <= ST_TURN;
                    end
                end
                ST_WRITE: begin
                    if (tmr_zero) begin
                        mem_we_n <= 1'b1;
                        gb_done  <= (gnt == GNT_GB);
                        host_ack <= (gnt == GNT_HOST);
                        state    <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    // CE and DQ are held through the first turnaround cycle only.
                    mem_ce_rom_n <= 1'b1;
                    mem_ce_ram_n <= 1'b1;
                    mem_dq_oe    <= 1'b0;
                    if (tmr_zero) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: directed scenarios plus
// randomized accesses against a memory model and an expected-content map.
module tb_cart_mem_arbiter;

    localparam int S = 1;
    localparam int A = 3;
    localparam int W = 2;
    localparam int T = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        gb_stb = 1'b0;
    logic        gb_sel_rom = 1'b0;
    logic        gb_sel_ram = 1'b0;
    logic        gb_we = 1'b0;
    logic [20:0] gb_adr = '0;
    logic [7:0]  gb_wdata = '0;
    logic [7:0]  gb_rdata;
    logic        gb_done;
    logic        gb_overrun;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [21:0] host_adr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic [20:0] mem_adr;
    logic [7:0]  mem_dq_o;
    logic [7:0]  mem_dq_i = '0;
    logic        mem_dq_oe;
    logic        mem_ce_rom_n;
    logic        mem_ce_ram_n;
    logic        mem_oe_n;
    logic        mem_we_n;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cart_mem_arbiter #(
        .SETUP_CYC  (S),
        .ACCESS_CYC (A),
        .WE_CYC     (W),
        .TURN_CYC   (T)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gb_stb       (gb_stb),
        .gb_sel_rom   (gb_sel_rom),
        .gb_sel_ram   (gb_sel_ram),
        .gb_we        (gb_we),
        .gb_adr       (gb_adr),
        .gb_wdata     (gb_wdata),
        .gb_rdata     (gb_rdata),
        .gb_done      (gb_done),
        .gb_overrun   (gb_overrun),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_adr     (host_adr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .host_ack     (host_ack),
        .mem_adr      (mem_adr),
        .mem_dq_o     (mem_dq_o),
        .mem_dq_i     (mem_dq_i),
        .mem_dq_oe    (mem_dq_oe),
        .mem_ce_rom_n (mem_ce_rom_n),
        .mem_ce_ram_n (mem_ce_ram_n),
        .mem_oe_n     (mem_oe_n),
        .mem_we_n     (mem_we_n)
    );

    // External memory model and bus monitor.
    logic [7:0]  smem [0:4194303];
    bit          swr  [0:4194303];
    logic [7:0]  gold [logic [21:0]];
    logic [21:0] mkey;

    int cyc = 0, rom_lo = 0, ram_lo = 0, oe_lo = 0, we_lo = 0;
    int rom_falls = 0, ram_falls = 0, done_n = 0, ack_n = 0, perr = 0;
    int rom_fall_cyc = 0, ram_fall_cyc = 0, done_cyc = 0, ack_cyc = 0;
    logic [20:0] rom_fall_adr = '0, ram_fall_adr = '0;
    logic [7:0]  we_dq = '0;
    logic        prev_rom_n = 1'b1, prev_ram_n = 1'b1;

    assign mkey = {~mem_ce_ram_n, mem_adr};

    function automatic logic [7:0] dflt(logic [21:0] k);
        return k[7:0] ^ k[15:8] ^ {2'b0, k[21:16]} ^ 8'h5C;
    endfunction

    function automatic logic [7:0] mread(logic [21:0] k);
        return swr[k] ? smem[k] : dflt(k);
    endfunction

    function automatic logic [7:0] gexp(logic [21:0] k);
        return gold.exists(k) ? gold[k] : dflt(k);
    endfunction

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        rom_lo <= rom_lo + int'(!mem_ce_rom_n);
        ram_lo <= ram_lo + int'(!mem_ce_ram_n);
        oe_lo  <= oe_lo + int'(!mem_oe_n);
        we_lo  <= we_lo + int'(!mem_we_n);
        if (prev_rom_n && !mem_ce_rom_n) begin
            rom_falls    <= rom_falls + 1;
            rom_fall_cyc <= cyc + 1;
            rom_fall_adr <= mem_adr;
        end
        if (prev_ram_n && !mem_ce_ram_n) begin
            ram_falls    <= ram_falls + 1;
            ram_fall_cyc <= cyc + 1;
            ram_fall_adr <= mem_adr;
        end
        prev_rom_n <= mem_ce_rom_n;
        prev_ram_n <= mem_ce_ram_n;
        if (gb_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc + 1;
        end
        if (host_ack) begin
            ack_n   <= ack_n + 1;
            ack_cyc <= cyc + 1;
        end
        if (!mem_we_n) begin
            we_dq      <= mem_dq_o;
            smem[mkey] <= mem_dq_o;
            swr[mkey]  <= 1'b1;
        end
        mem_dq_i <= !mem_oe_n ? mread(mkey) : 8'hEE;
        perr <= perr + int'(!mem_oe_n && !mem_we_n)
                     + int'(!mem_ce_rom_n && !mem_ce_ram_n)
                     + int'((!mem_oe_n || !mem_we_n) &&
                            mem_ce_rom_n && mem_ce_ram_n)
                     + int'(!mem_we_n && !mem_dq_oe)
                     + int'(!mem_oe_n && mem_dq_oe);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic host_go(logic we, logic [21:0] adr, logic [7:0] wd);
        host_we    = we;
        host_adr   = adr;
        host_wdata = wd;
        host_req   = 1'b1;
    endtask

    task automatic gb_pulse(logic rom, logic ram, logic we,
                            logic [20:0] adr, logic [7:0] wd);
        gb_sel_rom = rom;
        gb_sel_ram = ram;
        gb_we      = we;
        gb_adr     = adr;
        gb_wdata   = wd;
        gb_stb     = 1'b1;
        step();
        gb_stb     = 1'b0;
    endtask

    task automatic wait_host(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (host_ack) begin
                ok = 1'b1;
                host_req = 1'b0;
                break;
            end
        end
        host_req = 1'b0;
    endtask

    task automatic wait_gb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (gb_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        n_chk++;
        if ({mem_ce_rom_n, mem_ce_ram_n, mem_oe_n, mem_we_n, mem_dq_oe}
            !== 5'b11110) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 11110",
                     {mem_ce_rom_n, mem_ce_ram_n, mem_oe_n,
                      mem_we_n, mem_dq_oe});
        end
        n_chk++;
        if (mem_adr !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_adr: got %h want 0", mem_adr);
        end
        n_chk++;
        if ({gb_done, host_ack, gb_overrun} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000",
                     {gb_done, host_ack, gb_overrun});
        end
        n_chk++;
        if ({gb_rdata, host_rdata} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0000",
                     {gb_rdata, host_rdata});
        end
        reset_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_host_read();
        bit ok;
        int r0, o0, a0;
        host_go(1'b1, {1'b0, 21'h012345}, 8'h5A);
        wait_host(ok);
        gold[{1'b0, 21'h012345}] = 8'h5A;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL host_wr_ack: got timeout want ack");
        end
        repeat (3) step();
        r0 = rom_lo; o0 = oe_lo; a0 = ack_n;
        host_go(1'b0, {1'b0, 21'h012345}, 8'h00);
        wait_host(ok);
        repeat (3) step();
        n_chk++;
        if (!ok || host_rdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL host_rd_data: got %h ok=%0d want 5a",
                     host_rdata, ok);
        end
        n_chk++;
        if (rom_lo - r0 != S + A + 1) begin
            n_fail++;
            $display("FAIL host_rd_ce: got %0d want %0d",
                     rom_lo - r0, S + A + 1);
        end
        n_chk++;
        if (oe_lo - o0 != A) begin
            n_fail++;
            $display("FAIL host_rd_oe: got %0d want %0d", oe_lo - o0, A);
        end
        n_chk++;
        if (ack_cyc - rom_fall_cyc != S + A) begin
            n_fail++;
            $display("FAIL host_rd_lat: got %0d want %0d",
                     ack_cyc - rom_fall_cyc, S + A);
        end
        n_chk++;
        if (rom_fall_adr !== 21'h012345 || ack_n - a0 != 1) begin
            n_fail++;
            $display("FAIL host_rd_adr: got %h acks=%0d want 012345 acks=1",
                     rom_fall_adr, ack_n - a0);
        end
    endtask

    task automatic test_gb_write();
        bit ok;
        int r0, w0, d0;
        r0 = ram_lo; w0 = we_lo; d0 = done_n;
        gb_pulse(1'b0, 1'b1, 1'b1, 21'h00A123, 8'h3C);
        wait_gb(ok);
        gold[{1'b1, 21'h00A123}] = 8'h3C;
        repeat (4) step();
        n_chk++;
        if (!ok || done_n - d0 != 1) begin
            n_fail++;
            $display("FAIL gb_wr_done: got %0d ok=%0d want 1",
                     done_n - d0, ok);
        end
        n_chk++;
        if (ram_lo - r0 != S + W + 1) begin
            n_fail++;
            $display("FAIL gb_wr_ce: got %0d want %0d",
                     ram_lo - r0, S + W + 1);
        end
        n_chk++;
        if (we_lo - w0 != W) begin
            n_fail++;
            $display("FAIL gb_wr_we: got %0d want %0d", we_lo - w0, W);
        end
        n_chk++;
        if (we_dq !== 8'h3C || smem[{1'b1, 21'h00A123}] !== 8'h3C) begin
            n_fail++;
            $display("FAIL gb_wr_data: got %h/%h want 3c",
                     we_dq, smem[{1'b1, 21'h00A123}]);
        end
        n_chk++;
        if (ram_fall_adr !== 21'h00A123) begin
            n_fail++;
            $display("FAIL gb_wr_adr: got %h want 00a123", ram_fall_adr);
        end
    endtask

    task automatic test_priority();
        bit ok;
        host_go(1'b0, {1'b0, 21'h000100}, 8'h00);
        gb_pulse(1'b0, 1'b1, 1'b0, 21'h000200, 8'h00);
        wait_host(ok);
        repeat (3) step();
        n_chk++;
        if (!ok || ack_cyc - done_cyc != T + 1 + S + A) begin
            n_fail++;
            $display("FAIL prio_gap: got %0d ok=%0d want %0d",
                     ack_cyc - done_cyc, ok, T + 1 + S + A);
        end
        n_chk++;
        if (!(ram_fall_cyc < rom_fall_cyc)) begin
            n_fail++;
            $display("FAIL prio_order: got ram@%0d rom@%0d want ram first",
                     ram_fall_cyc, rom_fall_cyc);
        end
        n_chk++;
        if (gb_rdata !== gexp({1'b1, 21'h000200}) ||
            host_rdata !== gexp({1'b0, 21'h000100})) begin
            n_fail++;
            $display("FAIL prio_data: got %h/%h want %h/%h",
                     gb_rdata, host_rdata, gexp({1'b1, 21'h000200}),
                     gexp({1'b0, 21'h000100}));
        end
    endtask

    task automatic test_overrun();
        bit ok1, ok2;
        int d0;
        d0 = done_n;
        host_go(1'b0, {1'b0, 21'h000300}, 8'h00);
        step();
        gb_pulse(1'b0, 1'b1, 1'b0, 21'h000400, 8'h00);
        gb_pulse(1'b0, 1'b1, 1'b0, 21'h000401, 8'h00);
        wait_host(ok1);
        wait_gb(ok2);
        repeat (12) step();
        n_chk++;
        if (!ok1 || !ok2 || gb_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_flag: got %b ok=%0d%0d want 1",
                     gb_overrun, ok1, ok2);
        end
        n_chk++;
        if (done_n - d0 != 1 || ram_fall_adr !== 21'h000401) begin
            n_fail++;
            $display("FAIL ovr_one: got %0d @%h want 1 @000401",
                     done_n - d0, ram_fall_adr);
        end
        n_chk++;
        if (gb_rdata !== gexp({1'b1, 21'h000401})) begin
            n_fail++;
            $display("FAIL ovr_data: got %h want %h",
                     gb_rdata, gexp({1'b1, 21'h000401}));
        end
        n_chk++;
        if (done_cyc - ack_cyc != T + 1 + S + A) begin
            n_fail++;
            $display("FAIL ovr_wait: got %0d want %0d",
                     done_cyc - ack_cyc, T + 1 + S + A);
        end
    endtask

    task automatic test_reset_read();
        bit ok, seen;
        int a0;
        seen = 1'b0;
        host_go(1'b0, {1'b1, 21'h000055}, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step();
            if (!mem_oe_n) begin
                seen = 1'b1;
                break;
            end
        end
        a0 = ack_n;
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if (!seen ||
            {mem_ce_rom_n, mem_ce_ram_n, mem_oe_n, mem_we_n, mem_dq_oe}
            !== 5'b11110) begin
            n_fail++;
            $display("FAIL rst_mid: got %b seen=%0d want 11110",
                     {mem_ce_rom_n, mem_ce_ram_n, mem_oe_n,
                      mem_we_n, mem_dq_oe}, seen);
        end
        host_req = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (8) step();
        n_chk++;
        if (ack_n != a0 || gb_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_noack: got acks=%0d ovr=%b want 0 0",
                     ack_n - a0, gb_overrun);
        end
        host_go(1'b0, {1'b1, 21'h000055}, 8'h00);
        wait_host(ok);
        n_chk++;
        if (!ok || host_rdata !== gexp({1'b1, 21'h000055})) begin
            n_fail++;
            $display("FAIL rst_after: got %h ok=%0d want %h",
                     host_rdata, ok, gexp({1'b1, 21'h000055}));
        end
        repeat (3) step();
    endtask

    task automatic test_drop();
        bit ok;
        int rf0, a0, f0, d0;
        rf0 = rom_falls; a0 = ack_n;
        host_go(1'b0, {1'b0, 21'h000777}, 8'h00);
        step();
        n_chk++;
        if (mem_ce_rom_n !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_setup: got ce=%b want 0", mem_ce_rom_n);
        end
        host_req = 1'b0;
        wait_host(ok);
        n_chk++;
        if (!ok || host_rdata !== gexp({1'b0, 21'h000777})) begin
            n_fail++;
            $display("FAIL drop_ack: got %h ok=%0d want %h",
                     host_rdata, ok, gexp({1'b0, 21'h000777}));
        end
        repeat (3) step();
        gb_pulse(1'b0, 1'b1, 1'b0, 21'h000010, 8'h00);
        host_go(1'b0, {1'b0, 21'h000020}, 8'h00);
        step();
        host_req = 1'b0;
        wait_gb(ok);
        repeat (10) step();
        n_chk++;
        if (!ok || rom_falls - rf0 != 1 || ack_n - a0 != 1) begin
            n_fail++;
            $display("FAIL drop_pre: got rom=%0d acks=%0d ok=%0d want 1 1",
                     rom_falls - rf0, ack_n - a0, ok);
        end
        f0 = rom_falls + ram_falls; d0 = done_n;
        gb_pulse(1'b0, 1'b0, 1'b0, 21'h000123, 8'h00);
        repeat (10) step();
        n_chk++;
        if (rom_falls + ram_falls != f0 || done_n != d0) begin
            n_fail++;
            $display("FAIL nosel: got cycles=%0d dones=%0d want 0 0",
                     rom_falls + ram_falls - f0, done_n - d0);
        end
    endtask

    task automatic test_random();
        bit ok, gb, ram, we;
        logic [20:0] adr;
        logic [7:0] wd, rd;
        logic [21:0] key;
        int f0, lat, fc;
        logic [20:0] fa;
        for (int it = 0; it < 40; it++) begin
            gb  = 1'($urandom_range(0, 1));
            ram = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            if (gb && !ram) we = 1'b0;
            adr = 21'($urandom_range(0, 15));
            wd  = 8'($urandom);
            key = {ram, adr};
            f0  = ram ? ram_falls : rom_falls;
            if (gb) begin
                gb_pulse(~ram, ram, we, adr, wd);
                wait_gb(ok);
                lat = done_cyc;
                rd  = gb_rdata;
            end else begin
                host_go(we, key, wd);
                wait_host(ok);
                lat = ack_cyc;
                rd  = host_rdata;
            end
            fc = ram ? ram_fall_cyc : rom_fall_cyc;
            fa = ram ? ram_fall_adr : rom_fall_adr;
            n_chk++;
            if (!ok || (ram ? ram_falls : rom_falls) - f0 != 1 ||
                fa !== adr) begin
                n_fail++;
                $display("FAIL rnd_access[%0d]: got ok=%0d adr=%h want %h",
                         it, ok, fa, adr);
            end
            n_chk++;
            if (lat - fc != S + (we ? W : A)) begin
                n_fail++;
                $display("FAIL rnd_lat[%0d]: got %0d want %0d",
                         it, lat - fc, S + (we ? W : A));
            end
            if (we) begin
                gold[key] = wd;
            end else begin
                n_chk++;
                if (rd !== gexp(key)) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d]: got %h want %h",
                             it, rd, gexp(key));
                end
            end
            repeat ($urandom_range(0, 3)) step();
        end
        repeat (4) step();
    endtask

    task automatic test_protocol();
        n_chk++;
        if (perr != 0) begin
            n_fail++;
            $display("FAIL protocol: got %0d violations want 0", perr);
        end
    endtask

    initial begin
        test_reset();
        test_host_read();
        test_gb_write();
        test_priority();
        test_overrun();
        test_reset_read();
        test_drop();
        test_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
